// File: rtl/spi_master.sv
// SPI initiator for the SPI slave/RAM wrapper, running on the slave's own clk.
// It sends one 10-bit {op, payload} frame MSB first on MOSI while SS_n is low.
// For op 11 it then shifts in one byte from MISO and returns it as rd_data.
// done (and rd_valid for op 11) is high during the last SS_n-high gap cycle.
// In that same cycle busy is already low, so a new start can be accepted.
`timescale 1ns/1ps
module spi_master #(
  parameter int LEAD_CYC  = 2,
  parameter int TAIL_CYC  = 1,
  parameter int MISO_SKEW = 0,
  parameter int GAP_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS_n
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TAIL,
    SKEW,
    READ,
    GAP
  } state_t;

  // Phase counters are loaded with (length-1) and count down to zero.
  localparam logic [7:0] LEAD_INIT = 8'(LEAD_CYC - 1);
  localparam logic [7:0] TAIL_INIT = 8'(TAIL_CYC - 1);
  localparam logic [7:0] SKEW_INIT = 8'(MISO_SKEW - 1);
  localparam logic [7:0] GAP_INIT  = 8'(GAP_CYC - 1);
  localparam logic [7:0] BITS_INIT = 8'd9;
  localparam logic [7:0] READ_INIT = 8'd7;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [9:0]  shreg, shreg_nxt;
  logic [1:0]  op, op_nxt;
  logic [7:0]  rdsh, rdsh_nxt;
  logic        ss_n_nxt, mosi_nxt, busy_nxt, done_nxt, rd_valid_nxt;
  logic [7:0]  rd_data_nxt;
  logic        accept, go_lead, go_gap;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    op_nxt       = op;
    rdsh_nxt     = rdsh;
    ss_n_nxt     = SS_n;
    mosi_nxt     = MOSI;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    rd_valid_nxt = 1'b0;
    rd_data_nxt  = rd_data;
    accept       = start && !busy;
    go_lead      = 1'b0;
    go_gap       = 1'b0;

    case (state)
      IDLE: begin
        go_lead = accept;
      end

      LEAD: begin
        // MOSI already shows cmd[9]; the slave needs these cycles to reach its op state.
        if (cnt == 8'd0) begin
          state_nxt = SHIFT;
          cnt_nxt   = BITS_INIT;
          mosi_nxt  = shreg[9];
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      SHIFT: begin
        // shreg[9] is the bit on the wire now; shift so the next bit moves into [9].
        if (cnt == 8'd0) begin
          state_nxt = TAIL;
          cnt_nxt   = TAIL_INIT;
        end else begin
          mosi_nxt  = shreg[8];
          shreg_nxt = {shreg[8:0], 1'b0};
          cnt_nxt   = cnt - 8'd1;
        end
      end

      TAIL: begin
        if (cnt == 8'd0) begin
          if (op == 2'b11) begin
            if (MISO_SKEW == 0) begin
              state_nxt = READ;
              cnt_nxt   = READ_INIT;
            end else begin
              state_nxt = SKEW;
              cnt_nxt   = SKEW_INIT;
            end
          end else begin
            go_gap = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      SKEW: begin
        if (cnt == 8'd0) begin
          state_nxt = READ;
          cnt_nxt   = READ_INIT;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      READ: begin
        // The first sample lands in bit 7 once all eight have been shifted in.
        rdsh_nxt = {rdsh[6:0], MISO};
        if (cnt == 8'd0) begin
          rd_data_nxt = {rdsh[6:0], MISO};
          go_gap      = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      GAP: begin
        // The last gap cycle already shows done with busy low, so a start here chains frames.
        if (cnt == 8'd0) begin
          if (accept) begin
            go_lead = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) begin
            done_nxt     = 1'b1;
            busy_nxt     = 1'b0;
            rd_valid_nxt = (op == 2'b11);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (go_lead) begin
      state_nxt = LEAD;
      cnt_nxt   = LEAD_INIT;
      shreg_nxt = cmd;
      op_nxt    = cmd[9:8];
      ss_n_nxt  = 1'b0;
      mosi_nxt  = cmd[9];
      busy_nxt  = 1'b1;
    end

    if (go_gap) begin
      state_nxt = GAP;
      cnt_nxt   = GAP_INIT;
      ss_n_nxt  = 1'b1;
      if (GAP_INIT == 8'd0) begin
        done_nxt     = 1'b1;
        busy_nxt     = 1'b0;
        rd_valid_nxt = (op == 2'b11);
      end
    end
  end

  // State, phase counter and handshake outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      SS_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      SS_n     <= ss_n_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      rd_valid <= rd_valid_nxt;
    end
  end

  // Serial datapath registers: command shifter, latched op, MISO shifter, read result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= 10'd0;
      op      <= 2'b00;
      rdsh    <= 8'd0;
      MOSI    <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      shreg   <= shreg_nxt;
      op      <= op_nxt;
      rdsh    <= rdsh_nxt;
      MOSI    <= mosi_nxt;
      rd_data <= rd_data_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI slave/RAM model feeds the DUT's MISO.
// A scoreboard of expected frames is filled when starts are accepted.
// A monitor process compares each done pulse against the next scoreboard entry.
// A second instance with MISO_SKEW=1 talks to a slave that always returns 8'h5A.
`timescale 1ns/1ps
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [9:0] cmd0 = 10'd0, cmd1 = 10'd0;
  logic       busy0, done0, rd_valid0, mosi0, ss_n0;
  logic       busy1, done1, rd_valid1, mosi1, ss_n1;
  logic [7:0] rd_data0, rd_data1;
  logic       miso0 = 1'b0, miso1 = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  spi_master u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cmd(cmd0), .busy(busy0), .done(done0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .MOSI(mosi0), .MISO(miso0), .SS_n(ss_n0)
  );

  spi_master #(.MISO_SKEW(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmd(cmd1), .busy(busy1), .done(done1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .MOSI(mosi1), .MISO(miso1), .SS_n(ss_n1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Slave model (one per DUT) ----------------
  logic [7:0]  sl_mem [256];
  logic [7:0]  sl_waddr = 8'd0, sl_raddr = 8'd0;
  int          sl_pos [2]       = '{0, 0};
  int          sl_skew [2]      = '{0, 1};
  int          sl_last_len [2]  = '{0, 0};
  logic [12:0] sl_bits [2]      = '{13'd0, 13'd0};
  logic [12:0] sl_last_bits [2] = '{13'd0, 13'd0};
  logic        sl_rd_en [2]     = '{1'b0, 1'b0};
  logic [7:0]  sl_rbyte [2]     = '{8'd0, 8'd0};

  // Called #1 after each posedge: sees the SS_n/MOSI of the cycle that just began.
  task automatic slave_step(input int w, input logic ss, input logic mo, output logic mi);
    logic [7:0] pl;
    int k;
    mi = 1'($urandom);
    if (ss) begin
      if (sl_pos[w] != 0) begin
        sl_last_len[w]  = sl_pos[w];
        sl_last_bits[w] = sl_bits[w];
      end
      sl_pos[w]   = 0;
      sl_rd_en[w] = 1'b0;
    end else begin
      if (sl_pos[w] < 13) sl_bits[w] = {sl_bits[w][11:0], mo};
      if (sl_pos[w] == 12) begin
        pl = sl_bits[w][8:1];
        sl_rd_en[w] = (sl_bits[w][10:9] == 2'b11);
        if (w == 1) sl_rbyte[w] = 8'h5A;
        else begin
          case (sl_bits[w][10:9])
            2'b00:   sl_waddr = pl;
            2'b01:   sl_mem[sl_waddr] = pl;
            2'b10:   sl_raddr = pl;
            default: sl_rbyte[w] = sl_mem[sl_raddr];
          endcase
        end
      end
      k = sl_pos[w] - 13 - sl_skew[w];
      if (sl_rd_en[w] && k >= 0 && k < 8) mi = sl_rbyte[w][7-k];
      sl_pos[w]++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    slave_step(0, ss_n0, mosi0, miso0);
    slave_step(1, ss_n1, mosi1, miso1);
  end

  // ---------------- Reference model and scoreboard ----------------
  typedef struct {
    logic [9:0]  c;
    int          len;
    logic [12:0] bits;
    logic        rv;
    logic [7:0]  rd;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_mem [256];
  logic [7:0] m_waddr = 8'd0, m_raddr = 8'd0, m_rd = 8'd0;

  task automatic push_exp(input logic [9:0] c);
    exp_t e;
    case (c[9:8])
      2'b00:   m_waddr = c[7:0];
      2'b01:   m_mem[m_waddr] = c[7:0];
      2'b10:   m_raddr = c[7:0];
      default: m_rd = m_mem[m_raddr];
    endcase
    e.c    = c;
    e.len  = (c[9:8] == 2'b11) ? 21 : 13;
    e.bits = {c[9], c[9], c, c[0]};
    e.rv   = (c[9:8] == 2'b11);
    e.rd   = m_rd;
    sb.push_back(e);
  endtask

  // ---------------- Monitor ----------------
  int   hi_run = 0, last_hi_run = 0;
  logic ss_prev = 1'b1;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      ss_prev = 1'b1;
      hi_run  = 0;
    end else begin
      if (ss_n0) hi_run++;
      else if (ss_prev) begin
        last_hi_run = hi_run;
        hi_run = 0;
      end
      ss_prev = ss_n0;
      if (done0) begin
        if (sb.size() == 0) check("unexpected_done", 32'(done0), 32'd0);
        else begin
          e = sb.pop_front();
          check("ss_low_len",   32'(sl_last_len[0]), 32'(e.len));
          check("mosi_frame",   32'(sl_last_bits[0]), 32'(e.bits));
          check("rd_valid",     32'(rd_valid0), 32'(e.rv));
          check("busy_at_done", 32'(busy0), 32'd0);
          check("rd_data",      32'(rd_data0), 32'(e.rd));
        end
      end else if (rd_valid0) begin
        check("rd_valid_without_done", 32'(rd_valid0), 32'd0);
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic send(input logic [9:0] c);
    int t = 0;
    @(negedge clk);
    while (busy0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy0) check("send_busy_timeout", 32'(busy0), 32'd0);
    start0 = 1'b1;
    cmd0   = c;
    @(posedge clk);
    push_exp(c);
    #1;
    start0 = 1'b0;
    cmd0   = 10'($urandom);
    check("accept_busy", 32'(busy0), 32'd1);
    check("accept_ss_n", 32'(ss_n0), 32'd0);
    check("accept_mosi", 32'(mosi0), 32'(c[9]));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    logic [9:0] c;
    logic [9:0] u1_cmds [2];
    for (int i = 0; i < 256; i++) begin
      sl_mem[i] = 8'd0;
      m_mem[i]  = 8'd0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ss_n",     32'(ss_n0), 32'd1);
    check("rst_mosi",     32'(mosi0), 32'd0);
    check("rst_busy",     32'(busy0), 32'd0);
    check("rst_done",     32'(done0), 32'd0);
    check("rst_rd_valid", 32'(rd_valid0), 32'd0);
    check("rst_rd_data",  32'(rd_data0), 32'd0);

    // Reset in the middle of SHIFT aborts at once, with no done afterwards
    start0 = 1'b1;
    cmd0   = 10'h2A5;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_ss_n", 32'(ss_n0), 32'd1);
    check("abort_busy", 32'(busy0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_busy", 32'(busy0), 32'd0);

    // Write address, write data, then peek the slave memory
    send(10'h003);
    drain();
    send(10'h1B7);
    drain();
    check("slave_mem_03", 32'(sl_mem[8'h03]), 32'h0B7);

    // Read address then read data
    send(10'h203);
    send(10'h303);
    drain();
    check("read_back_B7", 32'(rd_data0), 32'h0B7);

    // Start during busy is ignored
    send(10'h055);
    repeat (4) @(negedge clk);
    check("busy_mid_frame", 32'(busy0), 32'd1);
    start0 = 1'b1;
    cmd0   = 10'h1FF;
    @(negedge clk);
    start0 = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    check("no_extra_frame", 32'(busy0), 32'd0);

    // Start held high across the frame: accepted in the done cycle, gap of one cycle
    send(10'h012);
    @(negedge clk);
    start0 = 1'b1;
    cmd0   = 10'h1C3;
    t = 0;
    while (!done0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b2b_done_seen", 32'(done0), 32'd1);
    @(posedge clk);
    push_exp(10'h1C3);
    #1 start0 = 1'b0;
    check("b2b_ss_fall", 32'(ss_n0), 32'd0);
    check("b2b_busy", 32'(busy0), 32'd1);
    drain();
    check("b2b_gap", 32'(last_hi_run), 32'd1);

    // Randomised traffic, mixing back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      c = 10'($urandom);
      send(c);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();

    // MISO_SKEW=1 instance: read address, then read data with a one-cycle-delayed reply
    u1_cmds[0] = 10'h203;
    u1_cmds[1] = 10'h300;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      start1 = 1'b1;
      cmd1   = u1_cmds[j];
      @(posedge clk);
      #1 start1 = 1'b0;
      t = 0;
      while (!done1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("skew_done_seen", 32'(done1), 32'd1);
      check("skew_rd_valid", 32'(rd_valid1), 32'(j));
      check("skew_ss_low_len", 32'(sl_last_len[1]), (j == 1) ? 32'd22 : 32'd13);
    end
    check("skew_rd_data", 32'(rd_data1), 32'h05A);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-clock SPI initiator that drives the existing SPI slave/RAM wrapper on MOSI/SS_n and captures MISO.
- The host issues 10-bit command frames: op[1:0] plus 8-bit payload, sent MSB first.
- op encodings: 00 write address, 01 write data, 10 read address, 11 read data.
- For op 11 the block receives 8 data bits on MISO and returns them to the host.
- The block sits between the host/CPU-side logic and the slave, sharing the slave's clk. There is no separate SCLK.

Parameters:
- LEAD_CYC, 2: cycles SS_n is low with MOSI=cmd[9] before bit 9 is shifted (slave IDLE->CHK_CMD->op state).
- TAIL_CYC, 1: cycles after bit 0 before the read phase or deassert.
- MISO_SKEW, 0: extra cycles after the tail before the first MISO sample.
- GAP_CYC, 1: minimum SS_n-high cycles between frames.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request frame; accepted only when busy=0
- cmd  in  10  {op[1:0], payload[7:0]}, sampled when start is accepted
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse at frame completion (end of GAP)
- rd_data  out  8  byte captured from MISO on op 11
- rd_valid  out  1  one-cycle pulse with done, for op 11 only
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave
- SS_n  out  1  active-low slave select

Behaviour:
- Reset (async, rst_n=0):
  - SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, state=IDLE.
  - Reset mid-frame aborts the frame immediately, with no done pulse.
- Registered state and outputs, all updated on posedge clk. FSM states: IDLE, LEAD, SHIFT, TAIL, SKEW, READ, GAP.
- IDLE:
  - On start=1: latch cmd into shreg and op.
  - Drive SS_n<=0, MOSI<=cmd[9], busy<=1. Go to LEAD with counter=LEAD_CYC-1.
- LEAD:
  - Hold MOSI=cmd[9] for LEAD_CYC cycles total (counting from the first SS_n-low cycle).
  - Then MOSI<=shreg[9] and go to SHIFT.
- SHIFT:
  - 10 cycles. MOSI presents shreg[9-i] for i=0..9, one bit per cycle, MSB first.
  - After bit 0's cycle, go to TAIL.
- TAIL:
  - TAIL_CYC cycles, MOSI holds bit 0.
  - Then: op==11 -> SKEW (or READ directly if MISO_SKEW=0); otherwise SS_n<=1 -> GAP.
- SKEW: MISO_SKEW cycles of waiting, SS_n low.
- READ:
  - 8 cycles. Each posedge: rdsh <= {rdsh[6:0], MISO}, so the first sample is bit 7.
  - After the 8th sample: rd_data<=captured byte, SS_n<=1 -> GAP.
- GAP:
  - GAP_CYC cycles with SS_n=1, busy=1.
  - On the last GAP cycle: done<=1; rd_valid<=1 if op==11; busy<=0; go to IDLE.
- SS_n-low length is fixed per frame:
  - Write or read-address frame: LEAD_CYC+10+TAIL_CYC = 13 cycles at defaults.
  - op 11: additionally MISO_SKEW+8 = 21 cycles at defaults.
- Start/busy handshake:
  - start with busy=1 is ignored; it is not queued.
  - start in the same cycle done=1 is accepted, and the next frame's SS_n falls one cycle after done. The gap is still >=GAP_CYC.
  - cmd changes after acceptance have no effect on the frame in flight.
- rd_data holds its value until the next op-11 frame completes. Write and op-10 frames do not alter rd_data.
- MISO is ignored outside READ.
- MOSI value while SS_n=1 is 0 after reset; after a frame it holds its last value (don't-care to the slave).
- The master does not enforce op ordering (e.g. 11 without a prior 10); that is the slave's concern.

Test Plan:
1. Reset mid-frame: assert rst_n=0 during SHIFT -> SS_n=1, busy=0 in the same cycle (async); no done. A subsequent start runs a full 13-cycle frame.
2. Write address: cmd={2'b00,8'h03} -> SS_n low exactly 13 cycles; MOSI = 0,0 (lead) then 0,0,0,0,0,0,0,0,1,1; done after 1 gap cycle; rd_valid=0.
3. Write data: cmd={2'b01,8'hB7} -> MOSI serial 0,1,1,0,1,1,0,1,1,1 after lead; slave RAM[0x03]=8'hB7 (bench peeks the slave memory).
4. Read address then read data against the slave wrapper: cmd={2'b10,8'h03}, then cmd={2'b11,8'h03} -> op-11 frame holds SS_n low 21 cycles; rd_data=8'hB7, rd_valid pulses once, coincident with done.
5. Busy/back-to-back: pulse start during busy -> ignored, no extra frame. Hold start high with a new cmd at the done cycle -> accepted; SS_n high for exactly GAP_CYC=1 cycle between frames.
6. Skew parameter: instantiate with MISO_SKEW=1 and drive MISO from a bench model delayed one cycle with pattern 8'h5A -> rd_data=8'h5A; SS_n-low length 22 cycles.
